// File: rtl/program_loader.sv
// Boot loader: packs a byte stream MSB-first into memory blocks, writes them through a
// request/ack handshake, then releases the CPU from reset and records when it halts.
module program_loader #(
  parameter int unsigned BLOCK_BITS = 64,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_data,
  input  logic                  in_last,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [BLOCK_BITS-1:0] mem_wr_data,
  input  logic                  mem_wr_ack,
  output logic                  cpu_run,
  input  logic                  cpu_halt,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   blocks_written
);

  localparam int unsigned NumBytes = BLOCK_BITS / 8;
  localparam int unsigned IdxW     = (NumBytes > 1) ? $clog2(NumBytes) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumBytes - 1);

  typedef enum logic [2:0] {StIdle, StFill, StWrite, StRun, StHalted} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BLOCK_BITS-1:0] data_q, data_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  last_q, last_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    idx_d   = idx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StHalted: begin
        if (start) begin
          state_d = StFill;
          addr_d  = base_addr;
          data_d  = '0;
          idx_d   = '0;
          last_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      StFill: begin
        if (in_valid) begin
          // Byte k lands at the k-th most significant lane; untouched lanes stay zero.
          for (int k = 0; k < NumBytes; k++) begin
            if (idx_q == IdxW'(k)) begin
              data_d[BLOCK_BITS-1-8*k -: 8] = in_data;
            end
          end
          idx_d = idx_q + IdxW'(1);
          if ((idx_q == LastIdx) || in_last) begin
            state_d = StWrite;
            last_d  = in_last;
          end
        end
      end
      StWrite: begin
        if (mem_wr_ack) begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          cnt_d   = cnt_q + (ADDR_WIDTH + 1)'(1);
          data_d  = '0;
          idx_d   = '0;
          state_d = last_q ? StRun : StFill;
        end
      end
      StRun: begin
        if (cpu_halt) begin
          state_d = StHalted;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign in_ready       = (state_q == StFill);
  assign mem_wr_en      = (state_q == StWrite);
  assign mem_wr_addr    = addr_q;
  assign mem_wr_data    = data_q;
  // The CPU stays released after halting so its state can be inspected.
  assign cpu_run        = (state_q == StRun) || (state_q == StHalted);
  assign busy           = (state_q == StFill) || (state_q == StWrite);
  assign done           = (state_q == StHalted);
  assign blocks_written = cnt_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: expected block writes are queued when bytes are
// driven and popped as the loader issues each memory write.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        in_last = 1'b0;
  logic        mem_wr_en;
  logic [15:0] mem_wr_addr;
  logic [63:0] mem_wr_data;
  logic        mem_wr_ack = 1'b0;
  logic        cpu_run;
  logic        cpu_halt = 1'b0;
  logic        busy;
  logic        done;
  logic [16:0] blocks_written;

  int total = 0;
  int bad = 0;

  logic [7:0]  stim [64];
  logic [79:0] sb [$];

  program_loader #(.BLOCK_BITS(64), .ADDR_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_ack(mem_wr_ack), .cpu_run(cpu_run), .cpu_halt(cpu_halt), .busy(busy),
    .done(done), .blocks_written(blocks_written)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a session, streams n bytes from stim, serves writes with ack_delay wait cycles
  // and checks every write against the scoreboard. Returns in the first RUN cycle.
  task automatic run_load(input logic [15:0] base, input int n, input int ack_delay,
                          input bit glitch);
    logic [15:0] a;
    logic [63:0] blk;
    logic [79:0] snap;
    logic [79:0] exp_w;
    int nblk;
    int p;
    int w;
    int fill;
    bit expect_wr;
    bit prev_ack;
    bit fin;
    bit glitched;
    sb.delete();
    a = base;
    blk = '0;
    nblk = 0;
    for (int i = 0; i < n; i++) begin
      blk[63-8*(i%8) -: 8] = stim[i];
      if ((i % 8 == 7) || (i == n - 1)) begin
        sb.push_back({a, blk});
        a = a + 16'd1;
        blk = '0;
        nblk++;
      end
    end

    start = 1'b1;
    base_addr = base;
    tick();
    start = 1'b0;
    total++;
    if (in_ready !== 1'b1 || cpu_run !== 1'b0 || done !== 1'b0 || blocks_written !== 17'd0) begin
      bad++;
      $display("FAIL start_state: ready=%b run=%b done=%b bw=%0d required 1 0 0 0",
               in_ready, cpu_run, done, blocks_written);
    end

    p = 0; w = 0; fill = 0; expect_wr = 0; prev_ack = 0; fin = 0; glitched = 0;
    snap = '0;
    for (int cyc = 0; cyc < 500 && !fin; cyc++) begin
      if (expect_wr) begin
        total++;
        if (mem_wr_en !== 1'b1) begin
          bad++;
          $display("FAIL wr_en_rise: mem_wr_en=%b required 1", mem_wr_en);
        end
      end
      expect_wr = 0;
      if (cpu_run === 1'b1) begin
        total++;
        if (!prev_ack) begin
          bad++;
          $display("FAIL run_after_ack: cpu_run=1 without ack on previous cycle");
        end
        total++;
        if (sb.size() != 0) begin
          bad++;
          $display("FAIL missing_writes: pending=%0d required 0", sb.size());
        end
        total++;
        if (blocks_written !== 17'(nblk)) begin
          bad++;
          $display("FAIL blocks_written: got %0d required %0d", blocks_written, nblk);
        end
        fin = 1;
      end else begin
        prev_ack = 0;
        if (mem_wr_en === 1'b1) begin
          total++;
          if (in_ready !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL write_flags: ready=%b busy=%b required 0 1", in_ready, busy);
          end
          if (w == 0) begin
            snap = {mem_wr_addr, mem_wr_data};
            total++;
            if (sb.size() == 0) begin
              bad++;
              $display("FAIL extra_write: addr=%h data=%h required none", mem_wr_addr,
                       mem_wr_data);
            end else begin
              exp_w = sb.pop_front();
              if (snap !== exp_w) begin
                bad++;
                $display("FAIL write: addr=%h data=%h required addr=%h data=%h",
                         snap[79:64], snap[63:0], exp_w[79:64], exp_w[63:0]);
              end
            end
          end else begin
            total++;
            if ({mem_wr_addr, mem_wr_data} !== snap) begin
              bad++;
              $display("FAIL write_stable: addr=%h data=%h required addr=%h data=%h",
                       mem_wr_addr, mem_wr_data, snap[79:64], snap[63:0]);
            end
          end
          mem_wr_ack = (w == ack_delay);
          prev_ack = mem_wr_ack;
          w++;
        end else begin
          w = 0;
          mem_wr_ack = 1'b0;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        start = 1'b0;
        if (in_ready === 1'b1 && p < n) begin
          if (glitch && p == 2 && !glitched) begin
            start = 1'b1;
            base_addr = 16'hBEEF;
            glitched = 1;
          end else begin
            in_valid = 1'b1;
            in_data = stim[p];
            in_last = (p == n - 1);
            fill++;
            if (fill == 8 || p == n - 1) begin
              expect_wr = 1;
              fill = 0;
            end
            p++;
          end
        end
        tick();
      end
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    start = 1'b0;
    mem_wr_ack = 1'b0;
    if (!fin) begin
      total++;
      bad++;
      $display("FAIL timeout: cpu_run=%b required 1 within 500 cycles", cpu_run);
    end
  endtask

  task automatic halt_cpu();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL done_in_run: done=%b required 0", done);
    end
    cpu_halt = 1'b1;
    tick();
    cpu_halt = 1'b0;
    total++;
    if (done !== 1'b1 || cpu_run !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL halt: done=%b run=%b busy=%b required 1 1 0", done, cpu_run, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({in_ready, mem_wr_en, mem_wr_addr, mem_wr_data, cpu_run, busy, done, blocks_written}
        !== '0) begin
      bad++;
      $display("FAIL reset: ready=%b en=%b addr=%h data=%h run=%b busy=%b done=%b bw=%0d",
               in_ready, mem_wr_en, mem_wr_addr, mem_wr_data, cpu_run, busy, done,
               blocks_written);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_block();
    for (int i = 0; i < 8; i++) stim[i] = 8'(i + 1);
    run_load(16'h0010, 8, 0, 0);
    halt_cpu();
  endtask

  task automatic test_partial();
    stim[0] = 8'hAA;
    stim[1] = 8'hBB;
    stim[2] = 8'hCC;
    run_load(16'h0040, 3, 0, 0);
    halt_cpu();
  endtask

  task automatic test_multi_delayed();
    for (int i = 0; i < 20; i++) stim[i] = 8'(i);
    run_load(16'h0100, 20, 3, 0);
    halt_cpu();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 16; i++) stim[i] = 8'(8'h30 + i);
    run_load(16'hFFFF, 16, 1, 0);
    halt_cpu();
  endtask

  task automatic test_reset_mid();
    bit saw_wr;
    saw_wr = 0;
    start = 1'b1;
    base_addr = 16'h0077;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data = 8'(8'hE0 + i);
      tick();
      if (mem_wr_en !== 1'b0) saw_wr = 1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    if (mem_wr_en !== 1'b0) saw_wr = 1;
    total++;
    if (saw_wr) begin
      bad++;
      $display("FAIL reset_mid_write: mem_wr_en pulsed required none");
    end
    total++;
    if ({in_ready, mem_wr_en, mem_wr_addr, mem_wr_data, cpu_run, busy, done, blocks_written}
        !== '0) begin
      bad++;
      $display("FAIL reset_mid: ready=%b en=%b addr=%h data=%h run=%b busy=%b done=%b bw=%0d",
               in_ready, mem_wr_en, mem_wr_addr, mem_wr_data, cpu_run, busy, done,
               blocks_written);
    end
    rst = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) stim[i] = 8'(8'h90 + i);
    run_load(16'h0200, 8, 2, 0);
    halt_cpu();
  endtask

  task automatic test_start_ignored();
    for (int i = 0; i < 8; i++) stim[i] = 8'(8'h5A ^ i);
    run_load(16'h0300, 8, 0, 1);
    halt_cpu();
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_partial();
    test_multi_delayed();
    test_wrap();
    test_reset_mid();
    test_start_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time program loader sitting directly upstream of `nand_cpu` and its `MEMORY`. It accepts a byte stream of machine code and packs it MSB-first into `CACHE_BLOCK_SIZE`-bit blocks, the same layout as the core memory image. It writes each block into memory through a write handshake and holds the CPU in reset until the whole image is written. It then releases the CPU and latches completion when the CPU reports `halt`.

## Interface
Parameters:
- `BLOCK_BITS`, default `` `CACHE_BLOCK_SIZE `` (64): memory block width; multiple of 8, ≥16.
- `ADDR_WIDTH`, default 16: memory block-address width.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a load session at `base_addr`; honoured only in IDLE and HALTED.
- `base_addr`  in  ADDR_WIDTH  first block address; sampled on accepted `start`.
- `in_valid`  in  1  byte-stream valid.
- `in_ready`  out  1  byte-stream ready.
- `in_data`  in  8  program byte.
- `in_last`  in  1  marks final byte of image; qualified by `in_valid`.
- `mem_wr_en`  out  1  block write request.
- `mem_wr_addr`  out  ADDR_WIDTH  block address.
- `mem_wr_data`  out  BLOCK_BITS  packed block.
- `mem_wr_ack`  in  1  memory accepts the write this cycle.
- `cpu_run`  out  1  CPU reset release; drives CPU `n_rst`.
- `cpu_halt`  in  1  CPU `halt`.
- `busy`  out  1  high in FILL or WRITE.
- `done`  out  1  high in HALTED.
- `blocks_written`  out  ADDR_WIDTH+1  blocks written in the current session.

## Operation
- States: IDLE, FILL, WRITE, RUN, HALTED.
- IDLE: `in_ready`=0, `cpu_run`=0. `start` → FILL. Loads addr=`base_addr`, clears packing register, byte index and `blocks_written`.
- FILL: `in_ready`=1. On handshake (`in_valid & in_ready`), byte k of the block lands in bits [BLOCK_BITS-1-8k -: 8], so the first byte is most significant, and k increments.
  - If k was BLOCK_BITS/8-1, or `in_last`=1, go to WRITE and record `last_seen`=`in_last`.
  - Unfilled bytes remain 0 (zero padding).
- WRITE: `mem_wr_en`=1. Address and data are held stable until `mem_wr_ack`; `in_ready`=0.
  - On ack: addr+1 (wraps mod 2^ADDR_WIDTH), `blocks_written`+1, clear register and index.
  - Then go to RUN if `last_seen`, else FILL.
- RUN: `cpu_run`=1. `cpu_halt`=1 → HALTED.
- HALTED: `cpu_run` stays 1 so memory and CPU state remain inspectable; `done`=1. `start` → FILL, which drops `cpu_run` and `done` and starts a new session.
- `start` is ignored in FILL, WRITE and RUN.
- `mem_wr_ack` is ignored when `mem_wr_en`=0. `cpu_halt` is ignored outside RUN.
- Reset in any state:
  - Go to IDLE; all outputs 0 from the next edge.
  - A partially packed block is discarded and never written.
  - The CPU returns to reset.

## Timing
- Reset values: `in_ready`=0, `mem_wr_en`=0, `mem_wr_addr`=0, `mem_wr_data`=0, `cpu_run`=0, `busy`=0, `done`=0, `blocks_written`=0.
- All outputs are decoded from registered state and registers; there is no combinational path from inputs to outputs.
- `start` sampled at edge N → `in_ready`=1 in cycle N+1.
- A full block needs BLOCK_BITS/8 handshake cycles. `mem_wr_en` rises the cycle after the last byte's handshake.
- Ack in the first WRITE cycle → `in_ready`=1 again the next cycle. Peak throughput is one block per BLOCK_BITS/8+1 cycles.
- `cpu_run` rises the cycle after the final write's ack.
- `done` rises the cycle after `cpu_halt` is sampled high in RUN.
- `in_last` on the byte that also fills the block produces exactly one write, then RUN.

## Test plan
- BLOCK_BITS=64, base 0x0010, bytes 01..08 with `in_last` on 08, ack tied 1 → one write, addr 0x0010, data 0x0102030405060708. `cpu_run`=1 the cycle after ack; `blocks_written`=1.
- Bytes AA,BB,CC with `in_last` on CC → one write, data 0xAABBCC0000000000; then RUN.
- 20 bytes 00..13, ack delayed 3 cycles per write → 3 writes at base, base+1, base+2. Third write data 0x1011121300000000. `in_ready`=0 and addr/data stable while `mem_wr_en` is waiting.
- base 0xFFFF, 16 bytes → writes at 0xFFFF then 0x0000; `blocks_written`=2.
- `rst` after 5 bytes in FILL → no `mem_wr_en` pulse, all outputs 0 next cycle. A following `start` with 8 bytes writes correctly at the new base.
- In RUN, `cpu_halt` pulses → `done`=1 next cycle and `cpu_run` stays 1. `start` during FILL is ignored. `start` in HALTED → `cpu_run`=0, `done`=0, `in_ready`=1 next cycle, `blocks_written`=0.
